p2p_rd_responder: RTL

- Peer-side AXI4 read responder for the P2P latency/throughput tests.
- Accepts inbound read requests on the PCIS-style slave read channels (AR/R) and queues them in a small FIFO.
- Returns each burst with a deterministic data pattern after a programmable response delay, and counts completed reads and beats.
- Configured and read back over the same cfg bus as the test controller; this gives the initiator a controllable, known-latency target.

---
 rtl/p2p_pkg.sv | 41 ++++
 rtl/p2p_ar_fifo.sv | 63 ++++++
 rtl/p2p_rd_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/p2p_pkg.sv
// Shared types, config map and data-pattern helper for the P2P read responder.
package p2p_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DLY,
        SEND
    } st_t;

    // Config register offsets from the window base.
    localparam logic [31:0] CTRL    = 32'h00;
    localparam logic [31:0] DELAY   = 32'h04;
    localparam logic [31:0] SEED    = 32'h08;
    localparam logic [31:0] RD_DONE = 32'h0C;
    localparam logic [31:0] BEATS   = 32'h10;
    localparam logic [31:0] STATUS  = 32'h14;

    localparam logic [31:0] BAD_ADDR = 32'h0BAD_F00D;

    // Queued IDs are stored at this width; the top's ID_W must not exceed it.
    localparam int MAX_ID_W = 32;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [31:0]         addr;
        logic [7:0]          len;
    } ar_entry_t;

    // Lane i of beat b carries seed + addr + 64*b + 4*i (mod 2^32).
    function automatic logic [511:0] beat_data(input logic [31:0] seed,
                                               input logic [31:0] addr,
                                               input logic [7:0]  beat);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = seed + addr + {18'd0, beat, 6'd0} + 32'(4 * i);
        end
        return d;
    endfunction

endpackage

// File: rtl/p2p_ar_fifo.sv
// Small synchronous FIFO holding accepted read requests until the responder
// is free to serve them.
module p2p_ar_fifo
    import p2p_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ar_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Write accepted entries into storage.
    // NOTE: the storage array is deliberately not reset; validity is defined
    // entirely by the pointers and count, so reset only needs to clear those.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Advance pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/p2p_rd_responder.sv
// Peer-side AXI4 read responder: queues AR requests, answers each burst with a
// deterministic pattern after a programmable delay, and counts completions.
module p2p_rd_responder
    import p2p_pkg::*;
#(
    parameter int          AR_FIFO_DEPTH = 4,
    parameter int          ID_W          = 16,
    parameter logic [31:0] CFG_BASE      = 32'hF00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic              cfg_rd,
    input  logic [31:0]       cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              rsp_cfg_ack,
    output logic [31:0]       cfg_rd_data,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [63:0]       s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [511:0]      s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready
);

    localparam int CW = $clog2(AR_FIFO_DEPTH) + 1;

    // Config state
    logic        enable;
    logic [31:0] resp_delay;
    logic [31:0] seed;
    logic [31:0] rd_done;
    logic [31:0] beat_cnt;
    logic [1:0]  ack_pipe;
    logic [31:0] rd_mux;
    logic        clr_cnt;

    // Request path
    ar_entry_t   fifo_din;
    ar_entry_t   fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic        fifo_push;
    logic        fifo_pop;

    // Response engine
    st_t         state;
    ar_entry_t   act;
    logic [31:0] cnt;
    logic [7:0]  beat;
    logic        fire;
    logic        busy;
    logic        unused_bits;

    assign s_rresp     = 2'b00;
    assign s_arready   = enable && !fifo_full;
    assign fifo_push   = s_arvalid && s_arready;
    assign fifo_din    = '{id: MAX_ID_W'(s_arid), addr: s_araddr[31:0], len: s_arlen};
    assign fifo_pop    = (state == IDLE) && !fifo_empty;
    assign fire        = s_rvalid && s_rready;
    assign busy        = (state != IDLE) || !fifo_empty;
    assign clr_cnt     = cfg_wr && (cfg_addr == CFG_BASE + CTRL) && cfg_wdata[1];
    assign rsp_cfg_ack = ack_pipe[1];
    // Upper address bits and padded ID bits are intentionally ignored.
    assign unused_bits = ^{s_araddr[63:32], act.id};

    p2p_ar_fifo #(
        .DEPTH   (AR_FIFO_DEPTH),
        .entry_t (ar_entry_t)
    ) u_ar_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Writable config registers; RO and unmapped writes fall through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable     <= 1'b0;
            resp_delay <= '0;
            seed       <= '0;
        end else if (cfg_wr) begin
            if (cfg_addr == CFG_BASE + CTRL)  enable     <= cfg_wdata[0];
            if (cfg_addr == CFG_BASE + DELAY) resp_delay <= cfg_wdata;
            if (cfg_addr == CFG_BASE + SEED)  seed       <= cfg_wdata;
        end
    end

    // Read-back decode.
    // NOTE: a default is assigned first so no path through the block leaves
    // rd_mux unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = BAD_ADDR;
        if      (cfg_addr == CFG_BASE + CTRL)    rd_mux = {31'd0, enable};
        else if (cfg_addr == CFG_BASE + DELAY)   rd_mux = resp_delay;
        else if (cfg_addr == CFG_BASE + SEED)    rd_mux = seed;
        else if (cfg_addr == CFG_BASE + RD_DONE) rd_mux = rd_done;
        else if (cfg_addr == CFG_BASE + BEATS)   rd_mux = beat_cnt;
        else if (cfg_addr == CFG_BASE + STATUS)  rd_mux = {24'd0, 4'(fifo_count), 3'd0, busy};
    end

    // Ack is a two-stage delay of any strobe; read data is captured on the
    // first stage and held so it is still valid when the ack appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_pipe    <= '0;
            cfg_rd_data <= '0;
        end else begin
            ack_pipe <= {ack_pipe[0], cfg_rd | cfg_wr};
            if (cfg_rd) cfg_rd_data <= rd_mux;
        end
    end

    // Completion counters; a clear in the same cycle as an increment wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_done  <= '0;
            beat_cnt <= '0;
        end else if (clr_cnt) begin
            rd_done  <= '0;
            beat_cnt <= '0;
        end else begin
            if (fire)            beat_cnt <= beat_cnt + 1'b1;
            if (fire && s_rlast) rd_done  <= rd_done + 1'b1;
        end
    end

    // Response FSM: pop a request, wait resp_delay cycles, then stream beats
    // with all R outputs registered and held while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            act      <= '0;
            cnt      <= '0;
            beat     <= '0;
            s_rvalid <= 1'b0;
            s_rlast  <= 1'b0;
            s_rid    <= '0;
            s_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        act   <= fifo_dout;
                        cnt   <= '0;
                        beat  <= '0;
                        state <= DLY;
                    end
                end
                DLY: begin
                    if (cnt == resp_delay) begin
                        state    <= SEND;
                        s_rvalid <= 1'b1;
                        s_rid    <= act.id[ID_W-1:0];
                        s_rdata  <= beat_data(seed, act.addr, 8'd0);
                        s_rlast  <= (act.len == 8'd0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (s_rready) begin
                        beat <= beat + 1'b1;
                        if (s_rlast) begin
                            s_rvalid <= 1'b0;
                            s_rlast  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            s_rdata <= beat_data(seed, act.addr, beat + 8'd1);
                            s_rlast <= ((beat + 8'd1) == act.len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
